round_key_store: RTL

- Downstream consumer of the single-round key expansion function.
- Accepts one 128-bit cipher key over a valid/ready handshake and iterates the AES-128 expansion step one round per clock.
- Stores round keys 0..NR in a register file and serves them to the round datapath through a registered read port indexed by round number.
- Reuses the codebase's combinational `rcon` (4-bit round in, 32-bit constant out) and `subByte` (32-bit) modules.

---
 rtl/round_key_store.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/round_key_store.sv
// AES-128 round-key store: expands one accepted key a round per clock into slots 0..NR.
// Optional macro ROUND_KEY_REV_READ_EN adds rd_rev for decryption-order reads.

module rcon (
    input  logic [3:0]  i_round,
    output logic [31:0] o_rcon
);
    always_comb begin
        o_rcon = '0;
        case (i_round)
            4'd1:    o_rcon = 32'h0100_0000;
            4'd2:    o_rcon = 32'h0200_0000;
            4'd3:    o_rcon = 32'h0400_0000;
            4'd4:    o_rcon = 32'h0800_0000;
            4'd5:    o_rcon = 32'h1000_0000;
            4'd6:    o_rcon = 32'h2000_0000;
            4'd7:    o_rcon = 32'h4000_0000;
            4'd8:    o_rcon = 32'h8000_0000;
            4'd9:    o_rcon = 32'h1b00_0000;
            4'd10:   o_rcon = 32'h3600_0000;
            default: o_rcon = '0;
        endcase
    end
endmodule

module subByte (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    always_comb begin
        o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                  sbox(i_word[15:8]),  sbox(i_word[7:0])};
    end
endmodule

module round_key_store #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
`ifdef ROUND_KEY_REV_READ_EN
    input  logic         rd_rev,
`endif
    output logic [127:0] rd_key,
    output logic         rd_err
);
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic         w_accept;
    logic         w_last;
    logic [3:0]   r_round;
    logic         r_key_ready;
    logic         r_busy;
    logic         r_done;
    logic         r_keys_valid;
    logic [127:0] r_rd_key;
    logic         r_rd_err;
    logic [127:0] r_slot [0:NR];

    logic [127:0] w_prev;
    logic [127:0] w_new;
    logic [31:0]  w_sub;
    logic [31:0]  w_rcon;
    logic [31:0]  w_t;
    logic [3:0]   w_rd_idx;

    assign key_ready  = r_key_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign keys_valid = r_keys_valid;
    assign rd_key     = r_rd_key;
    assign rd_err     = r_rd_err;

    // One expansion step from the previous round key.
    assign w_prev = r_slot[r_round - 4'd1];

    subByte u_sub (.i_word({w_prev[23:0], w_prev[31:24]}), .o_word(w_sub));
    rcon    u_rcon (.i_round(r_round), .o_rcon(w_rcon));

    assign w_t           = w_sub ^ w_rcon;
    assign w_new[127:96] = w_prev[127:96] ^ w_t;
    assign w_new[95:64]  = w_prev[95:64]  ^ w_new[127:96];
    assign w_new[63:32]  = w_prev[63:32]  ^ w_new[95:64];
    assign w_new[31:0]   = w_prev[31:0]   ^ w_new[63:32];

`ifdef ROUND_KEY_REV_READ_EN
    assign w_rd_idx = rd_rev ? (NR_L - rd_idx) : rd_idx;
`else
    assign w_rd_idx = rd_idx;
`endif

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE, READY: begin
                if (key_valid && r_key_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (r_round == NR_L) begin
                    w_last       = 1'b1;
                    w_state_next = READY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_round      <= '0;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            r_rd_key     <= '0;
            r_rd_err     <= 1'b0;
            for (int i = 0; i <= int'(NR); i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            r_state     <= w_state_next;
            r_key_ready <= (w_state_next != EXPAND);
            r_done      <= w_last;
            if (w_accept) begin
                r_slot[0]    <= key_in;
                r_round      <= 4'd1;
                r_keys_valid <= 1'b0;
                r_busy       <= 1'b1;
            end else if (r_state == EXPAND) begin
                r_slot[r_round] <= w_new;
                r_round         <= r_round + 4'd1;
                if (w_last) begin
                    r_busy       <= 1'b0;
                    r_keys_valid <= 1'b1;
                end
            end
            // Range check is on the raw index; a same-edge write is not yet visible.
            if (rd_idx <= NR_L) begin
                r_rd_key <= r_slot[w_rd_idx];
                r_rd_err <= 1'b0;
            end else begin
                r_rd_key <= '0;
                r_rd_err <= 1'b1;
            end
        end
    end
endmodule
